sha3_block_packer: RTL and testbench

//  Message-side writer for the SHA3-256 sponge: accepts a 64-bit word stream with a last flag and byte

---
 rtl/sha3_pkg.sv | 17 +
 rtl/sha3_pad_lane.sv | 24 ++
 rtl/sha3_block_packer.sv | 151 +++++++++++++++
 tb/tb_sha3_block_packer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared constants and state encoding for the SHA3-256 message block packer.
package sha3_pkg;

  localparam int          LANE_W     = 64;
  localparam int          RATE_LANES = 17;
  localparam int          RATE_BITS  = LANE_W * RATE_LANES;
  localparam int          RATE_BYTES = RATE_BITS / 8;
  localparam logic [7:0]  PAD_FIRST  = 8'h06;
  localparam logic [7:0]  PAD_LAST   = 8'h80;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HOLD  = 2'd1,
    EXTRA = 2'd2
  } state_e;

endpackage

// File: rtl/sha3_pad_lane.sv
// Masks the unused bytes of a message word and applies the SHA3 pad bytes that fall inside this lane.
module sha3_pad_lane
  import sha3_pkg::*;
#(
  parameter logic [7:0] DS_BYTE = PAD_FIRST
) (
  input  logic [LANE_W-1:0] word_i,
  input  logic [3:0]        bytes_i,
  input  logic              pad_first_en_i,
  input  logic              pad_last_en_i,
  output logic [LANE_W-1:0] lane_o
);

  always_comb begin
    // NOTE: lane_o gets a full default before the loop so no path leaves it unassigned (no latch).
    lane_o = '0;
    for (int k = 0; k < LANE_W / 8; k++) begin
      if (4'(k) < bytes_i) lane_o[8*k +: 8] = word_i[8*k +: 8];
      if (pad_first_en_i && (4'(k) == bytes_i)) lane_o[8*k +: 8] = lane_o[8*k +: 8] ^ DS_BYTE;
    end
    if (pad_last_en_i) lane_o[LANE_W-1 -: 8] = lane_o[LANE_W-1 -: 8] ^ PAD_LAST;
  end

endmodule

// File: rtl/sha3_block_packer.sv
// Packs a 64-bit message stream into padded 1088-bit SHA3-256 rate blocks.
// Optional macro SHA3_PACK_CNT_EN adds blk_cnt_o, the per-message block handshake count.
module sha3_block_packer
  import sha3_pkg::*;
#(
  parameter logic [7:0] DS_BYTE = PAD_FIRST
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [LANE_W-1:0]    in_data_i,
  input  logic                 in_last_i,
  input  logic [3:0]           in_bytes_i,
  output logic                 blk_valid_o,
  input  logic                 blk_ready_i,
  output logic [RATE_BITS-1:0] blk_data_o,
  output logic                 blk_last_o
`ifdef SHA3_PACK_CNT_EN
  ,
  output logic [15:0]          blk_cnt_o
`endif
);

  localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);

  state_e                               state_q;
  logic [4:0]                           idx_q;
  logic [RATE_LANES-1:0][LANE_W-1:0]    blk_q;
  logic                                 extra_pending_q;
  logic                                 in_ready_q;
  logic                                 blk_valid_q;
  logic                                 blk_last_q;

  logic [3:0]        nb_d;
  logic              full_last_d;
  logic              at_end_d;
  logic              accept_d;
  logic [LANE_W-1:0] lane_d;

  // Non-last words always carry 8 bytes; a last word's count is clamped to 8.
  assign nb_d        = !in_last_i ? 4'd8 : ((in_bytes_i > 4'd8) ? 4'd8 : in_bytes_i);
  assign full_last_d = in_last_i && (nb_d == 4'd8);
  assign at_end_d    = (idx_q == LAST_IDX);
  assign accept_d    = in_valid_i && in_ready_q;

  sha3_pad_lane #(.DS_BYTE(DS_BYTE)) u_pad_lane (
    .word_i         (in_data_i),
    .bytes_i        (nb_d),
    .pad_first_en_i (in_last_i && !full_last_d),
    .pad_last_en_i  (in_last_i && !full_last_d && at_end_d),
    .lane_o         (lane_d)
  );

  always_ff @(posedge clk) begin
    // NOTE: the block buffer is cleared on reset because unwritten lanes must read as zero.
    if (!rst_n) begin
      state_q         <= FILL;
      idx_q           <= '0;
      blk_q           <= '0;
      extra_pending_q <= 1'b0;
      in_ready_q      <= 1'b0;
      blk_valid_q     <= 1'b0;
      blk_last_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; later writes to the same lane win within a cycle.
      case (state_q)
        FILL: begin
          in_ready_q <= 1'b1;
          if (accept_d) begin
            blk_q[idx_q] <= lane_d;
            if (in_last_i) begin
              // A full last word pushes the first pad byte into the following lane.
              if (!at_end_d) blk_q[LAST_IDX] <= {PAD_LAST, 56'h0};
              if (full_last_d && !at_end_d) begin
                if (idx_q == LAST_IDX - 5'd1) blk_q[LAST_IDX] <= {PAD_LAST, 48'h0, DS_BYTE};
                else                          blk_q[idx_q + 5'd1] <= {56'h0, DS_BYTE};
              end
              extra_pending_q <= full_last_d && at_end_d;
              blk_last_q      <= !(full_last_d && at_end_d);
              state_q         <= HOLD;
              in_ready_q      <= 1'b0;
              blk_valid_q     <= 1'b1;
            end else if (at_end_d) begin
              blk_last_q  <= 1'b0;
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              blk_valid_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end
        end
        HOLD: begin
          if (blk_ready_i) begin
            blk_q       <= '0;
            idx_q       <= '0;
            blk_valid_q <= 1'b0;
            blk_last_q  <= 1'b0;
            if (extra_pending_q) begin
              state_q <= EXTRA;
            end else begin
              state_q    <= FILL;
              in_ready_q <= 1'b1;
            end
          end
        end
        EXTRA: begin
          blk_q[0]        <= {56'h0, DS_BYTE};
          blk_q[LAST_IDX] <= {PAD_LAST, 56'h0};
          extra_pending_q <= 1'b0;
          blk_last_q      <= 1'b1;
          blk_valid_q     <= 1'b1;
          state_q         <= HOLD;
        end
        default: begin
          state_q     <= FILL;
          in_ready_q  <= 1'b0;
          blk_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign blk_valid_o = blk_valid_q;
  assign blk_data_o  = blk_q;
  assign blk_last_o  = blk_last_q;

`ifdef SHA3_PACK_CNT_EN
  logic [15:0] cnt_q;
  logic        cnt_clear_q;

  // The count survives the final block and drops to zero once the next message starts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      cnt_clear_q <= 1'b0;
    end else if ((state_q == HOLD) && blk_ready_i) begin
      if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      if (blk_last_q) cnt_clear_q <= 1'b1;
    end else if (cnt_clear_q && accept_d) begin
      cnt_q       <= '0;
      cnt_clear_q <= 1'b0;
    end
  end

  assign blk_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_sha3_block_packer.sv
// Directed self-checking bench for sha3_block_packer (default build, no block counter).
module tb_sha3_block_packer;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready_o;
  logic [63:0]   in_data;
  logic          in_last;
  logic [3:0]    in_bytes;
  logic          blk_valid_o;
  logic          blk_ready;
  logic [1087:0] blk_data_o;
  logic          blk_last_o;

  int checks   = 0;
  int failures = 0;

  logic [1087:0] exp, got;
  logic          got_last;

  sha3_block_packer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .in_bytes_i  (in_bytes),
    .blk_valid_o (blk_valid_o),
    .blk_ready_i (blk_ready),
    .blk_data_o  (blk_data_o),
    .blk_last_o  (blk_last_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat_word(input int j);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(8*j + k);
    return w;
  endfunction

  function automatic logic [1087:0] pat_block(input int nbytes);
    logic [1087:0] b = '0;
    for (int i = 0; i < nbytes; i++) b[8*i +: 8] = 8'(i);
    return b;
  endfunction

  function automatic int bad_lane(input logic [1087:0] a, input logic [1087:0] b);
    for (int i = 0; i < 17; i++) if (a[64*i +: 64] !== b[64*i +: 64]) return i;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
    in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nb;
    for (int i = 0; i < 40; i++) begin
      if (in_ready_o === 1'b1) begin
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        return;
      end
      tick();
    end
    checks++; failures++;
    $display("FAIL send_timeout in_ready stayed %b, required 1", in_ready_o);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic take_blk(output logic [1087:0] d, output logic l);
    for (int i = 0; i < 40; i++) begin
      if (blk_valid_o === 1'b1) begin
        d = blk_data_o; l = blk_last_o;
        blk_ready = 1'b1;
        tick();
        blk_ready = 1'b0;
        return;
      end
      tick();
    end
    checks++; failures++;
    $display("FAIL blk_timeout blk_valid stayed %b, required 1", blk_valid_o);
    d = 'x; l = 1'bx;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pad_only(output logic [1087:0] b);
    b = '0; b[7:0] = 8'h06; b[1087:1080] = 8'h80;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = '0; blk_ready = 1'b0;
    tick(); tick();
    checks++; if (blk_valid_o !== 1'b0) begin failures++; $display("FAIL rst_blk_valid got=%b exp=0", blk_valid_o); end
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready_o); end
    checks++; if (blk_last_o !== 1'b0) begin failures++; $display("FAIL rst_blk_last got=%b exp=0", blk_last_o); end
    checks++; if (blk_data_o !== '0) begin failures++; $display("FAIL rst_blk_data lane=%0d nonzero", bad_lane(blk_data_o, '0)); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", in_ready_o); end
  endtask

  task automatic test_empty();
    send_word(64'h0, 1'b1, 4'd0);
    checks++; if (blk_valid_o !== 1'b1) begin failures++; $display("FAIL empty_latency blk_valid got=%b exp=1", blk_valid_o); end
    take_blk(got, got_last);
    pad_only(exp);
    checks++; if (got !== exp) begin failures++; $display("FAIL empty_data lane=%0d got=%h exp=%h", bad_lane(got, exp), got[64*bad_lane(got, exp) +: 64], exp[64*bad_lane(got, exp) +: 64]); end
    checks++; if (got_last !== 1'b1) begin failures++; $display("FAIL empty_last got=%b exp=1", got_last); end
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL empty_refill_ready got=%b exp=1", in_ready_o); end
  endtask

  task automatic test_abc();
    // Upper bytes carry junk that must be masked away.
    send_word(64'hDEAD_BEEF_FF63_6261, 1'b1, 4'd3);
    take_blk(got, got_last);
    exp = '0; exp[63:0] = 64'h0000_0000_0663_6261; exp[1087:1080] = 8'h80;
    checks++; if (got !== exp) begin failures++; $display("FAIL abc_data lane=%0d got=%h exp=%h", bad_lane(got, exp), got[64*bad_lane(got, exp) +: 64], exp[64*bad_lane(got, exp) +: 64]); end
    checks++; if (got_last !== 1'b1) begin failures++; $display("FAIL abc_last got=%b exp=1", got_last); end
  endtask

  task automatic test_full_last_mid();
    // 24 bytes: full last word at lane 2 with in_bytes>8 -> first pad byte lands in lane 3.
    send_word(pat_word(0), 1'b0, 4'd0);
    send_word(pat_word(1), 1'b0, 4'd0);
    send_word(pat_word(2), 1'b1, 4'd15);
    take_blk(got, got_last);
    exp = pat_block(24); exp[199:192] = 8'h06; exp[1087:1080] = 8'h80;
    checks++; if (got !== exp) begin failures++; $display("FAIL mid_full_data lane=%0d got=%h exp=%h", bad_lane(got, exp), got[64*bad_lane(got, exp) +: 64], exp[64*bad_lane(got, exp) +: 64]); end
    checks++; if (got_last !== 1'b1) begin failures++; $display("FAIL mid_full_last got=%b exp=1", got_last); end
  endtask

  task automatic test_135();
    for (int j = 0; j < 16; j++) send_word(pat_word(j), 1'b0, 4'd0);
    checks++; if (blk_valid_o !== 1'b0) begin failures++; $display("FAIL b135_early_valid got=%b exp=0", blk_valid_o); end
    send_word(pat_word(16), 1'b1, 4'd7);
    take_blk(got, got_last);
    exp = pat_block(135); exp[1087:1080] = 8'h86;
    checks++; if (got !== exp) begin failures++; $display("FAIL b135_data lane=%0d got=%h exp=%h", bad_lane(got, exp), got[64*bad_lane(got, exp) +: 64], exp[64*bad_lane(got, exp) +: 64]); end
    checks++; if (got_last !== 1'b1) begin failures++; $display("FAIL b135_last got=%b exp=1", got_last); end
  endtask

  task automatic test_136();
    for (int j = 0; j < 16; j++) send_word(pat_word(j), 1'b0, 4'd0);
    send_word(pat_word(16), 1'b1, 4'd8);
    take_blk(got, got_last);
    exp = pat_block(136);
    checks++; if (got !== exp) begin failures++; $display("FAIL b136_a_data lane=%0d got=%h exp=%h", bad_lane(got, exp), got[64*bad_lane(got, exp) +: 64], exp[64*bad_lane(got, exp) +: 64]); end
    checks++; if (got_last !== 1'b0) begin failures++; $display("FAIL b136_a_last got=%b exp=0", got_last); end
    checks++; if ({in_ready_o, blk_valid_o} !== 2'b00) begin failures++; $display("FAIL b136_extra_cycle ready,valid got=%b exp=00", {in_ready_o, blk_valid_o}); end
    take_blk(got, got_last);
    pad_only(exp);
    checks++; if (got !== exp) begin failures++; $display("FAIL b136_b_data lane=%0d got=%h exp=%h", bad_lane(got, exp), got[64*bad_lane(got, exp) +: 64], exp[64*bad_lane(got, exp) +: 64]); end
    checks++; if (got_last !== 1'b1) begin failures++; $display("FAIL b136_b_last got=%b exp=1", got_last); end
  endtask

  task automatic test_back_to_back();
    // 17 non-last words close an intermediate block; the tail goes into a second block.
    for (int j = 0; j < 17; j++) send_word(pat_word(j), 1'b0, 4'd0);
    take_blk(got, got_last);
    exp = pat_block(136);
    checks++; if (got !== exp) begin failures++; $display("FAIL b2b_a_data lane=%0d got=%h exp=%h", bad_lane(got, exp), got[64*bad_lane(got, exp) +: 64], exp[64*bad_lane(got, exp) +: 64]); end
    checks++; if (got_last !== 1'b0) begin failures++; $display("FAIL b2b_a_last got=%b exp=0", got_last); end
    send_word(64'h0000_0000_0063_6261, 1'b1, 4'd3);
    take_blk(got, got_last);
    exp = '0; exp[63:0] = 64'h0000_0000_0663_6261; exp[1087:1080] = 8'h80;
    checks++; if (got !== exp) begin failures++; $display("FAIL b2b_b_data lane=%0d got=%h exp=%h", bad_lane(got, exp), got[64*bad_lane(got, exp) +: 64], exp[64*bad_lane(got, exp) +: 64]); end
    checks++; if (got_last !== 1'b1) begin failures++; $display("FAIL b2b_b_last got=%b exp=1", got_last); end
  endtask

  task automatic test_backpressure();
    logic [1087:0] held;
    send_word(64'h0000_0000_4443_4241, 1'b1, 4'd4);
    checks++; if (blk_valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", blk_valid_o); end
    held = blk_data_o;
    exp = '0; exp[63:0] = 64'h0000_0006_4443_4241; exp[1087:1080] = 8'h80;
    checks++; if (held !== exp) begin failures++; $display("FAIL bp_data lane=%0d got=%h exp=%h", bad_lane(held, exp), held[64*bad_lane(held, exp) +: 64], exp[64*bad_lane(held, exp) +: 64]); end
    // Offer the next message while the block is stalled.
    in_valid = 1'b1; in_data = 64'h0000_0000_007A_7978; in_last = 1'b1; in_bytes = 4'd3;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (blk_data_o !== held) begin failures++; $display("FAIL bp_stable cycle=%0d lane=%0d changed", c, bad_lane(blk_data_o, held)); end
      checks++; if ({in_ready_o, blk_valid_o, blk_last_o} !== 3'b011) begin failures++; $display("FAIL bp_flags cycle=%0d ready,valid,last got=%b exp=011", c, {in_ready_o, blk_valid_o, blk_last_o}); end
    end
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
    checks++; if ({in_ready_o, blk_valid_o} !== 2'b10) begin failures++; $display("FAIL bp_after_hs ready,valid got=%b exp=10", {in_ready_o, blk_valid_o}); end
    send_word(64'h0000_0000_007A_7978, 1'b1, 4'd3);
    take_blk(got, got_last);
    exp = '0; exp[63:0] = 64'h0000_0000_067A_7978; exp[1087:1080] = 8'h80;
    checks++; if (got !== exp) begin failures++; $display("FAIL bp_held_word lane=%0d got=%h exp=%h", bad_lane(got, exp), got[64*bad_lane(got, exp) +: 64], exp[64*bad_lane(got, exp) +: 64]); end
  endtask

  task automatic test_reset_mid();
    for (int j = 0; j < 9; j++) send_word(pat_word(j), 1'b0, 4'd0);
    rst_n = 1'b0;
    tick();
    checks++; if ({in_ready_o, blk_valid_o} !== 2'b00) begin failures++; $display("FAIL rst_fill ready,valid got=%b exp=00", {in_ready_o, blk_valid_o}); end
    rst_n = 1'b1;
    send_word(64'h0000_0000_0063_6261, 1'b1, 4'd3);
    take_blk(got, got_last);
    exp = '0; exp[63:0] = 64'h0000_0000_0663_6261; exp[1087:1080] = 8'h80;
    checks++; if (got !== exp) begin failures++; $display("FAIL rst_fill_data lane=%0d got=%h exp=%h", bad_lane(got, exp), got[64*bad_lane(got, exp) +: 64], exp[64*bad_lane(got, exp) +: 64]); end
    for (int j = 0; j < 17; j++) send_word(pat_word(j), 1'b0, 4'd0);
    checks++; if (blk_valid_o !== 1'b1) begin failures++; $display("FAIL rst_hold_pre got=%b exp=1", blk_valid_o); end
    do_reset();
    checks++; if ({blk_valid_o, blk_last_o} !== 2'b00) begin failures++; $display("FAIL rst_hold valid,last got=%b exp=00", {blk_valid_o, blk_last_o}); end
    checks++; if (blk_data_o !== '0) begin failures++; $display("FAIL rst_hold_data lane=%0d nonzero", bad_lane(blk_data_o, '0)); end
    send_word(64'h0, 1'b1, 4'd0);
    take_blk(got, got_last);
    pad_only(exp);
    checks++; if (got !== exp) begin failures++; $display("FAIL rst_hold_next lane=%0d got=%h exp=%h", bad_lane(got, exp), got[64*bad_lane(got, exp) +: 64], exp[64*bad_lane(got, exp) +: 64]); end
    checks++; if (got_last !== 1'b1) begin failures++; $display("FAIL rst_hold_next_last got=%b exp=1", got_last); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_empty();
    test_abc();
    test_full_last_mid();
    test_135();
    test_136();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
